// File: rtl/mod_mul.sv
// mod_mul: pipelined Barrett modular multiplier, c = (a*b) mod q.
// Two hard-wired moduli are selected per operation: Q_DIL (select_i=0) or
// Q_KYB (select_i=1). One op per clock, results in issue order.
// Optional build macro MOD_MUL_OUT_REG_EN adds one output register stage
// (latency 4 instead of 3).
module mod_mul #(
  parameter int unsigned WIDTH = 23,
  parameter int unsigned Q_DIL = 8380417,
  parameter int unsigned Q_KYB = 3329
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             select_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] c_o
);

  // Product width and Barrett shift; k = product width keeps r below 2q.
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned K     = PW;
  localparam int unsigned Q_MIN = (Q_KYB < Q_DIL) ? Q_KYB : Q_DIL;
  localparam int unsigned Q_MAX = (Q_KYB < Q_DIL) ? Q_DIL : Q_KYB;
  // m = floor(2^k/q) and qhat both fit in MW bits for the smaller modulus.
  localparam int unsigned MW    = K - $clog2(Q_MIN) + 1;
  // Remainder width with headroom for r < 3q.
  localparam int unsigned RW    = $clog2(Q_MAX) + 2;
  localparam int unsigned XW    = PW + MW;

  localparam logic [63:0]    M_DIL_64 = (64'd1 << K) / 64'(Q_DIL);
  localparam logic [63:0]    M_KYB_64 = (64'd1 << K) / 64'(Q_KYB);
  localparam logic [MW-1:0]  M_DIL    = MW'(M_DIL_64);
  localparam logic [MW-1:0]  M_KYB    = MW'(M_KYB_64);
  localparam logic [RW-1:0]  Q_DIL_R  = RW'(Q_DIL);
  localparam logic [RW-1:0]  Q_KYB_R  = RW'(Q_KYB);

  // Stage registers
  logic             v1, v2, v3;
  logic             sel1, sel2, sel3;
  logic [WIDTH-1:0] a1, b1;
  logic [PW-1:0]    p2, p3;
  logic [MW-1:0]    qhat3;

  // Stage-3 result register
  logic             res_v;
  logic [WIDTH-1:0] res_c;

  // Combinational datapath
  logic [MW-1:0]    m_sel;
  logic [XW-1:0]    prod_pm;
  logic [MW-1:0]    qhat_n;
  logic [RW-1:0]    q_sel;
  logic [RW-1:0]    r0, r1, r2;
  logic [WIDTH-1:0] c_n;

  // Barrett estimate for the modulus travelling with stage 2.
  always_comb begin
    m_sel   = sel2 ? M_KYB : M_DIL;
    prod_pm = XW'(p2) * XW'(m_sel);
    qhat_n  = MW'(prod_pm >> K);
  end

  // Remainder (only low RW bits matter since r < 2^RW) and final correction.
  always_comb begin
    q_sel = sel3 ? Q_KYB_R : Q_DIL_R;
    r0    = RW'(p3) - (RW'(qhat3) * q_sel);
    r1    = (r0 >= q_sel) ? (r0 - q_sel) : r0;
    r2    = (r1 >= q_sel) ? (r1 - q_sel) : r1;
    c_n   = WIDTH'(r2);
  end

  // Valid pipeline; reset discards everything in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= valid_i;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Data pipeline; select stays aligned with its operands.
  always_ff @(posedge clk_i) begin
    a1    <= a_i;
    b1    <= b_i;
    sel1  <= select_i;
    p2    <= PW'(a1) * PW'(b1);
    sel2  <= sel1;
    p3    <= p2;
    qhat3 <= qhat_n;
    sel3  <= sel2;
  end

  // Stage-3 result register; c holds its value across bubbles.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      res_v <= 1'b0;
      res_c <= '0;
    end else begin
      res_v <= v3;
      if (v3) begin
        res_c <= c_n;
      end
    end
  end

`ifdef MOD_MUL_OUT_REG_EN
  logic             out_v;
  logic [WIDTH-1:0] out_c;

  // Extra output register stage.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_v <= 1'b0;
      out_c <= '0;
    end else begin
      out_v <= res_v;
      if (res_v) begin
        out_c <= res_c;
      end
    end
  end

  assign valid_o = out_v;
  assign c_o     = out_c;
`else
  assign valid_o = res_v;
  assign c_o     = res_c;
`endif

endmodule

// File: tb/tb_mod_mul.sv
// tb_mod_mul: self-checking bench for mod_mul. A delay-line model holds
// (a*b) % q per issued op; directed checks use the constant expectations.
module tb_mod_mul;

`ifdef MOD_MUL_OUT_REG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic [22:0] a_i;
  logic [22:0] b_i;
  logic        select_i;
  logic        valid_o;
  logic [22:0] c_o;

  int n_cmp  = 0;
  int n_fail = 0;

  bit          mq_v[$];
  logic [22:0] mq_c[$];
  logic [22:0] last_c = '0;

  mod_mul dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .select_i(select_i),
    .valid_o (valid_o),
    .c_o     (c_o)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] ref_mod(input logic [22:0] a, input logic [22:0] b,
                                          input bit s);
    longint unsigned q;
    longint unsigned p;
    q = s ? 64'd3329 : 64'd8380417;
    p = 64'(a) * 64'(b);
    return 23'(p % q);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare against it.
  task automatic step(input bit rst, input bit v, input logic [22:0] a, input logic [22:0] b,
                      input bit s);
    bit          exp_v;
    logic [22:0] exp_c;
    rst_ni   = ~rst;
    valid_i  = v;
    a_i      = a;
    b_i      = b;
    select_i = s;
    @(posedge clk);
    #1;
    exp_v = 1'b0;
    if (rst) begin
      mq_v.delete();
      mq_c.delete();
      last_c = '0;
    end else begin
      mq_v.push_back(v);
      mq_c.push_back(ref_mod(a, b, s));
      if (mq_v.size() > LAT) begin
        exp_v = mq_v.pop_front();
        exp_c = mq_c.pop_front();
        if (exp_v) last_c = exp_c;
      end
    end
    check("model valid_o", 32'(valid_o), 32'(exp_v));
    check("model c_o", 32'(c_o), 32'(last_c));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 23'd0, 23'd0, 1'b0);
  endtask

  task automatic expect_out(input string tag, input bit v, input logic [22:0] c);
    check({tag, " valid_o"}, 32'(valid_o), 32'(v));
    check({tag, " c_o"}, 32'(c_o), 32'(c));
  endtask

  // Issue a single op, wait the pipeline latency, check the constant result.
  task automatic single(input string tag, input logic [22:0] a, input logic [22:0] b,
                        input bit s, input logic [22:0] c);
    step(1'b0, 1'b1, a, b, s);
    repeat (LAT) idle();
    expect_out(tag, 1'b1, c);
  endtask

  initial begin
    rst_ni   = 1'b0;
    valid_i  = 1'b0;
    a_i      = '0;
    b_i      = '0;
    select_i = 1'b0;

    // Reset held with valid_i high: nothing emerges.
    repeat (5) step(1'b1, 1'b1, 23'd5, 23'd7, 1'b0);
    expect_out("reset", 1'b0, 23'd0);

    single("2*3", 23'd2, 23'd3, 1'b0, 23'd6);
    idle();
    expect_out("after single pulse", 1'b0, 23'd6);

    single("max dil", 23'd8380416, 23'd8380416, 1'b0, 23'd1);
    single("max kyb", 23'd3328, 23'd3328, 1'b1, 23'd1);
    single("q_dil*5", 23'd8380417, 23'd5, 1'b0, 23'd0);
    single("q_kyb*1", 23'd3329, 23'd1, 1'b1, 23'd0);
    single("oor dil", 23'd8388607, 23'd8388607, 1'b0, 23'd32764);
    single("oor kyb", 23'd8388607, 23'd1, 1'b1, 23'd2856);

    // Back-to-back alternating select.
    step(1'b0, 1'b1, 23'd3328, 23'd3328, 1'b1);
    step(1'b0, 1'b1, 23'd8380416, 23'd2, 1'b0);
    step(1'b0, 1'b1, 23'd0, 23'd7, 1'b1);
    step(1'b0, 1'b1, 23'd100, 23'd100, 1'b0);
    repeat (LAT - 3) idle();
    expect_out("b2b 0", 1'b1, 23'd1);
    idle();
    expect_out("b2b 1", 1'b1, 23'd8380415);
    idle();
    expect_out("b2b 2", 1'b1, 23'd0);
    idle();
    expect_out("b2b 3", 1'b1, 23'd10000);

    // Op, bubble, op.
    step(1'b0, 1'b1, 23'd10, 23'd10, 1'b1);
    idle();
    step(1'b0, 1'b1, 23'd5, 23'd5, 1'b0);
    repeat (LAT - 2) idle();
    expect_out("bubble op0", 1'b1, 23'd100);
    idle();
    expect_out("bubble gap", 1'b0, 23'd100);
    idle();
    expect_out("bubble op1", 1'b1, 23'd25);

    // Reset with two ops in flight.
    step(1'b0, 1'b1, 23'd11, 23'd13, 1'b0);
    step(1'b0, 1'b1, 23'd17, 23'd19, 1'b1);
    step(1'b1, 1'b1, 23'd23, 23'd29, 1'b0);
    for (int i = 0; i < LAT + 2; i++) begin
      idle();
      expect_out("mid reset", 1'b0, 23'd0);
    end

    // Random ops with occasional bubbles.
    for (int i = 0; i < 3000; i++) begin
      step(1'b0, ($urandom_range(9) != 0), 23'($urandom), 23'($urandom),
           1'($urandom_range(1)));
    end
    repeat (LAT + 1) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
